spi_slave: RTL
==============

SPI_SLAVE -- requirements
Module: spi_slave

Interface
REQ-001 Parameter CPOL, default 0: SCLK idle level; leading edge is rising when 0, falling when 1.
REQ-002 Parameter CPHA, default 0: 0 = sample on leading edge, shift on trailing; 1 = shift on leading, sample on trailing.
REQ-003 Parameter FSB, default 0: 0 = MSB first, 1 = LSB first, same order for MOSI and MISO.
REQ-004 Parameter WIDTH, default 8: bits per word, legal range 2..32.
REQ-005 clk  input  1  system clock; frequency SHALL be at least 4x SCLK frequency.
REQ-006 rst  input  1  reset, synchronous, active-high.
REQ-007 spi_sclk  input  1  SPI clock from master, asynchronous to clk.
REQ-008 spi_ss_n  input  1  slave select, active-low, asynchronous.
REQ-009 spi_mosi  input  1  master-out data, asynchronous.
REQ-010 spi_miso  output  1  slave-out data.
REQ-011 spi_tx_data  input  WIDTH  word to transmit; sampled at word start (REQ-016).
REQ-012 spi_rx_data  output  WIDTH  last completely received word.
REQ-013 spi_valid  output  1  one-cycle pulse: spi_rx_data updated.
REQ-014 spi_busy  output  1  high while a frame is in progress (synchronised SS low).

Function
REQ-015 spi_sclk, spi_ss_n, spi_mosi SHALL each pass a 2-flop synchroniser; edges detected from the synchronised SCLK and the flop behind it; synchroniser flops reset to sclk=CPOL, ss_n=1, mosi=0.
REQ-016 FSM states IDLE, SHIFT. IDLE->SHIFT on synchronised SS falling: load spi_tx_data into tx shifter, bit counter=0. SHIFT->IDLE on synchronised SS high.
REQ-017 CPHA=0: first tx bit SHALL be on spi_miso the cycle after entering SHIFT; sample MOSI on each leading edge; present next bit on each trailing edge.
REQ-018 CPHA=1: present next bit on each leading edge (first bit on first leading edge); sample MOSI on each trailing edge.
REQ-019 On the WIDTH-th sample, the cycle after: spi_rx_data = assembled word, spi_valid = 1 for exactly one cycle, bit counter = 0.
REQ-020 Back-to-back words in one SS assertion: on the WIDTH-th sample spi_tx_data SHALL be reloaded into the tx shifter; next word's first bit presented per REQ-017/018 without gap.
REQ-021 SS deassert mid-word: abort; no spi_valid; spi_rx_data unchanged; partial bits discarded; return to IDLE.
REQ-022 SCLK edges while SS high SHALL be ignored.
REQ-023 Sample and SS-high in the same cycle: SS-high wins; no spi_valid for a partial word.
REQ-024 spi_busy = 1 exactly while in SHIFT.
REQ-025 In IDLE, spi_miso SHALL be 0 (see REQ-030 for the tri-state build).
REQ-026 Latency from pin SCLK sampling edge to internal sample SHALL be 3 clk cycles; spi_valid follows the final sample by 1 cycle.

Reset
REQ-027 When rst=1 at a clk edge: state=IDLE, bit counter=0, shifters=0, spi_rx_data=0, spi_valid=0, spi_busy=0, spi_miso=0.
REQ-028 Reset mid-frame SHALL abort with no spi_valid; after release a frame is recognised only on a fresh SS falling edge.

Configuration
REQ-029 Macro SPI_SLAVE_MISO_TRISTATE_EN selects MISO drive.
REQ-030 Defined: spi_miso SHALL be high-impedance whenever synchronised SS is high or rst is active; driven only in SHIFT.
REQ-031 Not defined: spi_miso SHALL be driven 0 outside SHIFT (REQ-025); no Z on the port.

Verification
REQ-032 CPOL=0,CPHA=0,FSB=0,WIDTH=8, clk 10x SCLK; master sends 0xA5, spi_tx_data=0x3C -> spi_rx_data=0xA5, one spi_valid pulse, master receives 0x3C.
REQ-033 Loopback (MISO tied to MOSI at the master), WIDTH=16, words 0x1234 then 0xBEEF in one SS assertion -> two spi_valid pulses, values 0x1234 and 0xBEEF; master receives the spi_tx_data values sampled at each word start.
REQ-034 All four CPOL/CPHA modes with FSB=1, master sends 0x01 -> spi_rx_data=0x01 in every mode; MISO bit order LSB first.
REQ-035 SS raised after 5 of 8 bits of 0xFF -> no spi_valid, spi_rx_data keeps previous 0xA5; next full frame 0x5A -> 0x5A.
REQ-036 rst asserted for 1 cycle mid-word -> all outputs at reset values the next cycle; no spi_valid; following frame 0xC3 received correctly.
REQ-037 With and without SPI_SLAVE_MISO_TRISTATE_EN: MISO is Z / 0 respectively while SS high, and matches REQ-032 data while SS low.

Source files
------------

// File: rtl/spi_slave.sv
// spi_slave: SPI slave with a 2-flop synchronised front end and a configurable
// CPOL/CPHA/bit order. The word width is set by WIDTH.
// Build option: define SPI_SLAVE_MISO_TRISTATE_EN to release spi_miso to
// high-impedance whenever the slave is not selected. Without it, spi_miso is
// driven to 0 outside a frame.
module spi_slave #(
    parameter int CPOL  = 0,
    parameter int CPHA  = 0,
    parameter int FSB   = 0,
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             spi_sclk,
    input  logic             spi_ss_n,
    input  logic             spi_mosi,
    output logic             spi_miso,
    input  logic [WIDTH-1:0] spi_tx_data,
    output logic [WIDTH-1:0] spi_rx_data,
    output logic             spi_valid,
    output logic             spi_busy
);

    localparam int             CW       = $clog2(WIDTH);
    localparam logic           IDLE_LVL = (CPOL != 0);
    localparam logic [CW-1:0]  LAST_BIT = CW'(WIDTH - 1);

    typedef enum logic {IDLE, SHIFT} state_t;

    state_t           state_reg, state_next;
    logic             sclk_meta_reg, sclk_sync_reg, sclk_prev_reg;
    logic             ss_meta_reg, ss_sync_reg;
    logic             mosi_meta_reg, mosi_sync_reg;
    logic [1:0]       settle_reg;
    logic             armed_reg;
    logic [CW-1:0]    bit_cnt_reg;
    logic [WIDTH-1:0] tx_shift_reg, rx_shift_reg, rx_data_reg;
    logic             valid_reg, skip_reg;
    logic [WIDTH-1:0] rx_next, tx_next;
    logic             miso_bit;
    logic             sclk_change, lead_edge, trail_edge, sample_edge, shift_edge;
    logic             enter;

    // Synchronise the asynchronous SPI pins; track whether SS has been seen
    // high since reset so a select held low across reset is not taken as a frame.
    always_ff @(posedge clk) begin
        if (rst) begin
            sclk_meta_reg <= IDLE_LVL;
            sclk_sync_reg <= IDLE_LVL;
            sclk_prev_reg <= IDLE_LVL;
            ss_meta_reg   <= 1'b1;
            ss_sync_reg   <= 1'b1;
            mosi_meta_reg <= 1'b0;
            mosi_sync_reg <= 1'b0;
            settle_reg    <= 2'b00;
            armed_reg     <= 1'b0;
        end else begin
            sclk_meta_reg <= spi_sclk;
            sclk_sync_reg <= sclk_meta_reg;
            sclk_prev_reg <= sclk_sync_reg;
            ss_meta_reg   <= spi_ss_n;
            ss_sync_reg   <= ss_meta_reg;
            mosi_meta_reg <= spi_mosi;
            mosi_sync_reg <= mosi_meta_reg;
            settle_reg    <= {settle_reg[0], 1'b1};
            armed_reg     <= armed_reg | (settle_reg[1] & ss_sync_reg);
        end
    end

    assign sclk_change = sclk_sync_reg ^ sclk_prev_reg;
    assign lead_edge   = sclk_change && (sclk_sync_reg != IDLE_LVL);
    assign trail_edge  = sclk_change && (sclk_sync_reg == IDLE_LVL);
    assign sample_edge = (CPHA != 0) ? trail_edge : lead_edge;
    assign shift_edge  = (CPHA != 0) ? lead_edge : trail_edge;

    // Bit order: shift direction and which end of the word is on the wire.
    generate
        if (FSB != 0) begin : g_lsb_first
            assign rx_next  = {mosi_sync_reg, rx_shift_reg[WIDTH-1:1]};
            assign tx_next  = {1'b0, tx_shift_reg[WIDTH-1:1]};
            assign miso_bit = tx_shift_reg[0];
        end else begin : g_msb_first
            assign rx_next  = {rx_shift_reg[WIDTH-2:0], mosi_sync_reg};
            assign tx_next  = {tx_shift_reg[WIDTH-2:0], 1'b0};
            assign miso_bit = tx_shift_reg[WIDTH-1];
        end
    endgenerate

    // Frame state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next state: a frame opens on a fresh SS low and closes as soon as SS is high.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (armed_reg && !ss_sync_reg) state_next = SHIFT;
            SHIFT:   if (ss_sync_reg) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    assign enter = (state_reg == IDLE) && (state_next == SHIFT);

    // Shifters, bit counter and word delivery. skip_reg holds the freshly
    // loaded first bit across the next shift edge (leading edge for CPHA=1,
    // the trailing edge right after a word boundary for CPHA=0).
    always_ff @(posedge clk) begin
        if (rst) begin
            bit_cnt_reg  <= '0;
            tx_shift_reg <= '0;
            rx_shift_reg <= '0;
            rx_data_reg  <= '0;
            valid_reg    <= 1'b0;
            skip_reg     <= 1'b0;
        end else begin
            valid_reg <= 1'b0;
            if (enter) begin
                tx_shift_reg <= spi_tx_data;
                rx_shift_reg <= '0;
                bit_cnt_reg  <= '0;
                skip_reg     <= (CPHA != 0);
            end else if (state_reg == SHIFT && !ss_sync_reg) begin
                if (sample_edge) begin
                    rx_shift_reg <= rx_next;
                    if (bit_cnt_reg == LAST_BIT) begin
                        bit_cnt_reg  <= '0;
                        rx_data_reg  <= rx_next;
                        valid_reg    <= 1'b1;
                        tx_shift_reg <= spi_tx_data;
                        skip_reg     <= 1'b1;
                    end else begin
                        bit_cnt_reg <= bit_cnt_reg + 1'b1;
                    end
                end
                if (shift_edge) begin
                    if (skip_reg) begin
                        skip_reg <= 1'b0;
                    end else begin
                        tx_shift_reg <= tx_next;
                    end
                end
            end else if (state_reg == SHIFT) begin
                // SS went high: drop the partial word.
                bit_cnt_reg  <= '0;
                rx_shift_reg <= '0;
                tx_shift_reg <= '0;
                skip_reg     <= 1'b0;
            end
        end
    end

    assign spi_rx_data = rx_data_reg;
    assign spi_valid   = valid_reg;
    assign spi_busy    = (state_reg == SHIFT);

`ifdef SPI_SLAVE_MISO_TRISTATE_EN
    assign spi_miso = (state_reg == SHIFT && !ss_sync_reg && !rst) ? miso_bit : 1'bz;
`else
    assign spi_miso = (state_reg == SHIFT) ? miso_bit : 1'b0;
`endif

endmodule
